// File: rtl/sap1_controller.sv
// SAP-1 controller-sequencer: six-state one-hot T-ring plus opcode decode into the datapath control word.
// Control word is combinational from the T-state; the ring advances on run or a step rising edge.
module sap1_controller (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] opcode_i,
    input  logic       run_i,
    input  logic       step_i,
    output logic [5:0] t_state_o,
    output logic       pc_inc_o,
    output logic       pc_out_o,
    output logic       mar_load_o,
    output logic       ram_out_o,
    output logic       ir_load_o,
    output logic       ir_out_o,
    output logic       a_load_o,
    output logic       a_out_o,
    output logic       b_load_o,
    output logic       alu_out_o,
    output logic       sub_o,
    output logic       out_load_o,
    output logic       halt_o,
    output logic       instr_done_o
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } tstate_e;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    tstate_e state_q, state_d;
    logic    halted_q, halted_d;
    logic    step_q;
    logic    hlt_now;
    logic    step_rise;
    logic    adv;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= T1;
            halted_q <= 1'b0;
            step_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
            step_q   <= step_i;
        end
    end

    always_comb begin
        state_d      = state_q;
        halted_d     = halted_q;
        pc_inc_o     = 1'b0;
        pc_out_o     = 1'b0;
        mar_load_o   = 1'b0;
        ram_out_o    = 1'b0;
        ir_load_o    = 1'b0;
        ir_out_o     = 1'b0;
        a_load_o     = 1'b0;
        a_out_o      = 1'b0;
        b_load_o     = 1'b0;
        alu_out_o    = 1'b0;
        sub_o        = 1'b0;
        out_load_o   = 1'b0;
        instr_done_o = 1'b0;

        hlt_now   = (state_q == T4) && (opcode_i == OP_HLT);
        step_rise = step_i && !step_q;
        adv       = !halted_q && !hlt_now && (run_i || step_rise);

        if (adv) begin
            if (state_q == T6) state_d = T1;
            else               state_d = tstate_e'({state_q[4:0], 1'b0});
        end
        if (hlt_now) halted_d = 1'b1;

        // Reset and a latched halt both silence the whole control word.
        if (rst_ni && !halted_q) begin
            instr_done_o = (state_q == T6) && adv;
            case (state_q)
                T1: begin pc_out_o = 1'b1; mar_load_o = 1'b1; end
                T2: pc_inc_o = 1'b1;
                T3: begin ram_out_o = 1'b1; ir_load_o = 1'b1; end
                T4: begin
                    case (opcode_i)
                        OP_LDA, OP_ADD, OP_SUB: begin ir_out_o = 1'b1; mar_load_o = 1'b1; end
                        OP_OUT:                 begin a_out_o = 1'b1; out_load_o = 1'b1; end
                        default:                ;
                    endcase
                end
                T5: begin
                    case (opcode_i)
                        OP_LDA:         begin ram_out_o = 1'b1; a_load_o = 1'b1; end
                        OP_ADD, OP_SUB: begin ram_out_o = 1'b1; b_load_o = 1'b1; end
                        default:        ;
                    endcase
                end
                T6: begin
                    if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
                        alu_out_o = 1'b1;
                        a_load_o  = 1'b1;
                        sub_o     = (opcode_i == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign halt_o    = rst_ni && (halted_q || hlt_now);
    assign t_state_o = state_q;

endmodule

// File: tb/tb_sap1_controller.sv
// Bench for sap1_controller: table of per-cycle vectors feeding a scoreboard, hand sequences, random invariant run.
module tb_sap1_controller;

    logic       clk;
    logic       rst_n;
    logic [3:0] opcode;
    logic       run;
    logic       step;
    logic [5:0] t_state;
    logic pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out;
    logic a_load, a_out, b_load, alu_out, sub, out_load, halt, instr_done;

    sap1_controller dut (
        .clk_i(clk), .rst_ni(rst_n), .opcode_i(opcode), .run_i(run), .step_i(step),
        .t_state_o(t_state), .pc_inc_o(pc_inc), .pc_out_o(pc_out), .mar_load_o(mar_load),
        .ram_out_o(ram_out), .ir_load_o(ir_load), .ir_out_o(ir_out), .a_load_o(a_load),
        .a_out_o(a_out), .b_load_o(b_load), .alu_out_o(alu_out), .sub_o(sub),
        .out_load_o(out_load), .halt_o(halt), .instr_done_o(instr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word bit positions: {pc_inc,pc_out,mar_load,ram_out,ir_load,ir_out,a_load,a_out,b_load,alu_out,sub,out_load,halt,instr_done}
    localparam logic [13:0] PI = 14'h2000, PO = 14'h1000, ML = 14'h0800, RO = 14'h0400;
    localparam logic [13:0] IL = 14'h0200, IO = 14'h0100, AL = 14'h0080, AO = 14'h0040;
    localparam logic [13:0] BL = 14'h0020, LO = 14'h0010, SU = 14'h0008, OL = 14'h0004;
    localparam logic [13:0] HL = 14'h0002, DN = 14'h0001, Z = 14'h0000;
    localparam logic [3:0]  LDA = 4'b0000, ADD = 4'b0001, SUB = 4'b0010, OUTI = 4'b1110, HLT = 4'b1111;
    localparam logic [5:0]  S1 = 6'h01, S2 = 6'h02, S3 = 6'h04, S4 = 6'h08, S5 = 6'h10, S6 = 6'h20;

    typedef struct {
        logic       rst_n;
        logic       run;
        logic       step;
        logic [3:0] op;
        logic       chk_t;
        logic [5:0] t;
        logic [13:0] ctl;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_n = 0;
    bit   started = 0;

    function automatic vec_t mk(logic r, logic ru, logic s, logic [3:0] o, logic c, logic [5:0] t, logic [13:0] w);
        vec_t v;
        v.rst_n = r; v.run = ru; v.step = s; v.op = o; v.chk_t = c; v.t = t; v.ctl = w;
        return v;
    endfunction

    task automatic drive(input vec_t v, input bit push);
        @(posedge clk);
        #1;
        rst_n = v.rst_n; run = v.run; step = v.step; opcode = v.op;
        started = 1;
        if (push) sb.push_back(v);
    endtask

    task automatic cyc(logic r, logic ru, logic s, logic [3:0] o, logic [5:0] t, logic [13:0] w);
        drive(mk(r, ru, s, o, 1'b1, t, w), 1'b1);
    endtask

    always @(negedge clk) begin
        logic [13:0] act;
        vec_t e;
        act = {pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out, a_load, a_out,
               b_load, alu_out, sub, out_load, halt, instr_done};
        cyc_n++;
        if (started) begin
            n_cmp++;
            if (!$onehot(t_state)) begin
                n_bad++;
                $display("FAIL onehot cyc=%0d t_state=%b required one-hot", cyc_n, t_state);
            end
            n_cmp++;
            if ($countones({pc_out, ram_out, ir_out, a_out, alu_out}) > 1) begin
                n_bad++;
                $display("FAIL bus_drivers cyc=%0d drivers=%b required at most one", cyc_n,
                         {pc_out, ram_out, ir_out, a_out, alu_out});
            end
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk_t) begin
                n_cmp++;
                if (t_state !== e.t) begin
                    n_bad++;
                    $display("FAIL t_state cyc=%0d got=%h want=%h", cyc_n, t_state, e.t);
                end
            end
            n_cmp++;
            if (act !== e.ctl) begin
                n_bad++;
                $display("FAIL ctl_word cyc=%0d got=%h want=%h", cyc_n, act, e.ctl);
            end
        end
    end

    initial begin
        logic [13:0] lda_ctl [6];
        int nadv;
        bit prev_s;
        rst_n = 1'b0; run = 1'b0; step = 1'b0; opcode = LDA;

        // Reset, then LDA, SUB, ADD, OUT and HLT back to back in free-run.
        tbl.push_back(mk(0, 0, 0, LDA,  0, S1, Z));
        tbl.push_back(mk(0, 1, 0, LDA,  1, S1, Z));
        tbl.push_back(mk(1, 1, 0, LDA,  1, S1, PO | ML));
        tbl.push_back(mk(1, 1, 0, LDA,  1, S2, PI));
        tbl.push_back(mk(1, 1, 0, LDA,  1, S3, RO | IL));
        tbl.push_back(mk(1, 1, 0, LDA,  1, S4, IO | ML));
        tbl.push_back(mk(1, 1, 0, LDA,  1, S5, RO | AL));
        tbl.push_back(mk(1, 1, 0, LDA,  1, S6, DN));
        tbl.push_back(mk(1, 1, 0, SUB,  1, S1, PO | ML));
        tbl.push_back(mk(1, 1, 0, SUB,  1, S2, PI));
        tbl.push_back(mk(1, 1, 0, SUB,  1, S3, RO | IL));
        tbl.push_back(mk(1, 1, 0, SUB,  1, S4, IO | ML));
        tbl.push_back(mk(1, 1, 0, SUB,  1, S5, RO | BL));
        tbl.push_back(mk(1, 1, 0, SUB,  1, S6, LO | AL | SU | DN));
        tbl.push_back(mk(1, 1, 0, ADD,  1, S1, PO | ML));
        tbl.push_back(mk(1, 1, 0, ADD,  1, S2, PI));
        tbl.push_back(mk(1, 1, 0, ADD,  1, S3, RO | IL));
        tbl.push_back(mk(1, 1, 0, ADD,  1, S4, IO | ML));
        tbl.push_back(mk(1, 1, 0, ADD,  1, S5, RO | BL));
        tbl.push_back(mk(1, 1, 0, ADD,  1, S6, LO | AL | DN));
        tbl.push_back(mk(1, 1, 0, OUTI, 1, S1, PO | ML));
        tbl.push_back(mk(1, 1, 0, OUTI, 1, S2, PI));
        tbl.push_back(mk(1, 1, 0, OUTI, 1, S3, RO | IL));
        tbl.push_back(mk(1, 1, 0, OUTI, 1, S4, AO | OL));
        tbl.push_back(mk(1, 1, 0, OUTI, 1, S5, Z));
        tbl.push_back(mk(1, 1, 0, OUTI, 1, S6, DN));
        tbl.push_back(mk(1, 1, 0, HLT,  1, S1, PO | ML));
        tbl.push_back(mk(1, 1, 0, HLT,  1, S2, PI));
        tbl.push_back(mk(1, 1, 0, HLT,  1, S3, RO | IL));
        tbl.push_back(mk(1, 1, 0, HLT,  1, S4, HL));
        tbl.push_back(mk(1, 1, 0, HLT,  1, S4, HL));
        for (int i = 0; i < tbl.size(); i++) drive(tbl[i], 1'b1);

        // Halted: opcode back to LDA, run and step wiggling, ring must sit in T4.
        for (int i = 0; i < 20; i++) cyc(1, i[1], i[0], LDA, S4, HL);

        // Reset while halted clears halt and restarts fetch.
        cyc(0, 0, 0, LDA, S4, Z);
        cyc(0, 0, 0, LDA, S1, Z);
        cyc(1, 0, 0, LDA, S1, PO | ML);

        // Single-step: four 3-cycle step pulses walk T1 -> T5.
        lda_ctl[0] = PO | ML; lda_ctl[1] = PI; lda_ctl[2] = RO | IL;
        lda_ctl[3] = IO | ML; lda_ctl[4] = RO | AL; lda_ctl[5] = DN;
        nadv = 0;
        prev_s = 0;
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 5; k++) begin
                bit s;
                logic [5:0] et;
                s  = (k < 3);
                et = 6'b000001 << nadv;
                cyc(1, 0, s, LDA, et, lda_ctl[nadv]);
                if (s && !prev_s) nadv++;
                prev_s = s;
            end
        end
        n_cmp++;
        if (nadv != 4 || t_state !== S5) begin
            n_bad++;
            $display("FAIL step_count t_state=%h want=%h", t_state, S5);
        end

        // Step rising under run gives no extra advance; run dropping freezes the ring.
        cyc(1, 1, 1, LDA, S5, RO | AL);
        cyc(1, 0, 1, LDA, S6, Z);
        cyc(1, 0, 1, LDA, S6, Z);
        cyc(1, 0, 0, LDA, S6, Z);
        cyc(1, 0, 1, LDA, S6, DN);
        cyc(1, 0, 0, LDA, S1, PO | ML);

        // Reset during T5 of ADD.
        cyc(1, 1, 0, ADD, S1, PO | ML);
        cyc(1, 1, 0, ADD, S2, PI);
        cyc(1, 1, 0, ADD, S3, RO | IL);
        cyc(1, 1, 0, ADD, S4, IO | ML);
        cyc(0, 1, 0, ADD, S5, Z);
        cyc(0, 1, 0, ADD, S1, Z);
        cyc(1, 1, 0, ADD, S1, PO | ML);
        cyc(1, 1, 0, ADD, S2, PI);
        cyc(1, 1, 0, ADD, S3, RO | IL);

        // Random opcodes and run, invariants only.
        for (int i = 0; i < 500; i++) begin
            logic [3:0] o;
            o = 4'($urandom_range(0, 15));
            drive(mk(($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     o, 1'b0, S1, Z), 1'b0);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
